// File: rtl/spio_uart_pkt_ser.sv
// SpiNNaker packet to UART byte-stream serialiser: sync, header, key, optional payload, optional checksum.
// Optional feature macro SPIO_UART_PKT_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module spio_uart_pkt_ser #(
    parameter logic [7:0] SYNC_BYTE  = 8'h7E,
    parameter int         GAP_CYCLES = 0
) (
    input  logic        tx_clk_i,
    input  logic        rx_reset_i,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    input  logic        CTS_IN,
    output logic [7:0]  BYTE_DATA_OUT,
    output logic        BYTE_VLD_OUT,
    input  logic        BYTE_RDY_IN,
    output logic        BUSY_OUT
);

    localparam int GW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HDR  = 3'd2,
        ST_KEY  = 3'd3,
        ST_PLD  = 3'd4,
        ST_CHK  = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    state_t        end_state_s;
    state_t        after_data_s;
    logic [71:0]   pkt_r;
    logic [1:0]    cnt_r;
    logic [GW-1:0] gap_cnt_r;
    logic [7:0]    byte_data_r;
    logic          byte_vld_r;
    logic          pkt_rdy_r;
    logic          busy_r;
    logic          accept_s;
    logic          xfer_s;
    logic          frame_end_s;
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
    logic [7:0]    chk_r;
    logic          last_data_s;
`endif

    assign accept_s    = PKT_VLD_IN && pkt_rdy_r;
    assign xfer_s      = byte_vld_r && BYTE_RDY_IN;
    assign end_state_s = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
    assign after_data_s = ST_CHK;
    assign last_data_s  = xfer_s && (cnt_r == 2'd3) &&
                          (((state_r == ST_KEY) && !pkt_r[1]) || (state_r == ST_PLD));
`else
    assign after_data_s = end_state_s;
`endif
    assign frame_end_s = xfer_s && ((state_next_s == ST_IDLE) || (state_next_s == ST_GAP));

    assign PKT_RDY_OUT   = pkt_rdy_r;
    assign BYTE_DATA_OUT = byte_data_r;
    assign BYTE_VLD_OUT  = byte_vld_r;
    assign BUSY_OUT      = busy_r;

    // Next-state decode; every in-frame step advances only on a byte transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_SYNC;
                else          state_next_s = ST_IDLE;
            end
            ST_SYNC: begin
                if (xfer_s) state_next_s = ST_HDR;
                else        state_next_s = ST_SYNC;
            end
            ST_HDR: begin
                if (xfer_s) state_next_s = ST_KEY;
                else        state_next_s = ST_HDR;
            end
            ST_KEY: begin
                if (xfer_s && (cnt_r == 2'd3)) begin
                    if (pkt_r[1]) state_next_s = ST_PLD;
                    else          state_next_s = after_data_s;
                end else begin
                    state_next_s = ST_KEY;
                end
            end
            ST_PLD: begin
                if (xfer_s && (cnt_r == 2'd3)) state_next_s = after_data_s;
                else                           state_next_s = ST_PLD;
            end
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer_s) state_next_s = end_state_s;
                else        state_next_s = ST_CHK;
            end
`endif
            ST_GAP: begin
                if (gap_cnt_r == {GW{1'b0}}) state_next_s = ST_IDLE;
                else                         state_next_s = ST_GAP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, holding register and registered byte/handshake outputs.
    always_ff @(posedge tx_clk_i or negedge rx_reset_i) begin
        if (!rx_reset_i) begin
            state_r     <= ST_IDLE;
            pkt_r       <= 72'h0;
            cnt_r       <= 2'd0;
            gap_cnt_r   <= {GW{1'b0}};
            byte_data_r <= 8'h00;
            byte_vld_r  <= 1'b0;
            pkt_rdy_r   <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
            chk_r       <= 8'h00;
`endif
        end else begin
            state_r   <= state_next_s;
            pkt_rdy_r <= (state_next_s == ST_IDLE) && CTS_IN;
            busy_r    <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        pkt_r       <= PKT_DATA_IN;
                        byte_data_r <= SYNC_BYTE;
                        byte_vld_r  <= 1'b1;
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
                        chk_r       <= 8'h00;
`endif
                    end
                end
                ST_SYNC: if (xfer_s) byte_data_r <= pkt_r[7:0];
                ST_HDR: begin
                    if (xfer_s) begin
                        byte_data_r <= pkt_r[15:8];
                        cnt_r       <= 2'd0;
                    end
                end
                // Key and payload go out least significant byte first.
                ST_KEY: begin
                    if (xfer_s && (cnt_r != 2'd3)) begin
                        cnt_r       <= cnt_r + 2'd1;
                        byte_data_r <= pkt_r[16 + 8*int'(cnt_r) +: 8];
                    end else if (xfer_s && pkt_r[1]) begin
                        cnt_r       <= 2'd0;
                        byte_data_r <= pkt_r[47:40];
                    end
                end
                ST_PLD: begin
                    if (xfer_s && (cnt_r != 2'd3)) begin
                        cnt_r       <= cnt_r + 2'd1;
                        byte_data_r <= pkt_r[48 + 8*int'(cnt_r) +: 8];
                    end
                end
                ST_GAP: if (gap_cnt_r != {GW{1'b0}}) gap_cnt_r <= gap_cnt_r - GW'(1);
                default: ;
            endcase
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
            if (xfer_s && ((state_r == ST_HDR) || (state_r == ST_KEY) || (state_r == ST_PLD)))
                chk_r <= chk_r ^ byte_data_r;
            // The checksum byte must include the data byte transferring this cycle.
            if (last_data_s) byte_data_r <= chk_r ^ byte_data_r;
`endif
            if (frame_end_s) byte_vld_r <= 1'b0;
            if (frame_end_s && (state_next_s == ST_GAP)) gap_cnt_r <= GAP_LOAD;
        end
    end

endmodule

// File: tb/tb_spio_uart_pkt_ser.sv
// Directed bench for spio_uart_pkt_ser: frame model queue, per-cycle byte compare, literal pins.
module tb_spio_uart_pkt_ser;
    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n, cts, pkt_vld, pkt_vld_g, byte_rdy;
    logic [71:0] pkt_data;
    logic        pkt_rdy, byte_vld, busy;
    logic [7:0]  byte_data;
    logic        g_pkt_rdy, g_byte_vld, g_busy;
    logic [7:0]  g_byte_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int g_last_cyc = 0;
    int g_gap_cnt = 0;
    int acc_cyc = 0;
    int g_gap_at_acc = 0;
    byte_q_t exp_q, exp_g_q, obs_q, lit1, lit2;
    int obs_cyc_q [$];
    logic       stall_m = 1'b0;
    logic       end_pend = 1'b0;
    logic       end_cts = 1'b0;
    logic [7:0] held_m = 8'h00;
    logic [7:0] exp_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spio_uart_pkt_ser dut (
        .tx_clk_i(clk), .rx_reset_i(rst_n), .PKT_DATA_IN(pkt_data), .PKT_VLD_IN(pkt_vld),
        .PKT_RDY_OUT(pkt_rdy), .CTS_IN(cts), .BYTE_DATA_OUT(byte_data), .BYTE_VLD_OUT(byte_vld),
        .BYTE_RDY_IN(byte_rdy), .BUSY_OUT(busy)
    );

    spio_uart_pkt_ser #(.GAP_CYCLES(3)) dut_g (
        .tx_clk_i(clk), .rx_reset_i(rst_n), .PKT_DATA_IN(pkt_data), .PKT_VLD_IN(pkt_vld_g),
        .PKT_RDY_OUT(g_pkt_rdy), .CTS_IN(cts), .BYTE_DATA_OUT(g_byte_data), .BYTE_VLD_OUT(g_byte_vld),
        .BYTE_RDY_IN(byte_rdy), .BUSY_OUT(g_busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame as the byte list the sink must see.
    function automatic byte_q_t frame_bytes(input logic [7:0] hdr, input logic [31:0] key,
                                            input logic [31:0] pld);
        byte_q_t q;
        logic [7:0] x;
        q.push_back(8'h7E);
        q.push_back(hdr);
        for (int i = 0; i < 4; i++) q.push_back(key[8*i +: 8]);
        if (hdr[1]) for (int i = 0; i < 4; i++) q.push_back(pld[8*i +: 8]);
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 1; i < q.size(); i++) x = x ^ q[i];
        q.push_back(x);
`else
        x = 8'h00;
`endif
        return q;
    endfunction

    task automatic send(input bit g, input logic [7:0] hdr, input logic [31:0] key, input logic [31:0] pld);
        byte_q_t f;
        bit ok;
        ok = 1'b0;
        f = frame_bytes(hdr, key, pld);
        foreach (f[i]) begin
            if (g) exp_g_q.push_back(f[i]);
            else   exp_q.push_back(f[i]);
        end
        pkt_data = {pld, key, hdr};
        if (g) pkt_vld_g = 1'b1;
        else   pkt_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if ((g ? g_pkt_rdy : pkt_rdy) == 1'b1) begin
                acc_cyc = cyc + 1;
                g_gap_at_acc = g_gap_cnt;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        pkt_vld = 1'b0;
        pkt_vld_g = 1'b0;
        check("accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input bit g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (g ? (exp_g_q.size() == 0 && !g_busy) : (exp_q.size() == 0 && !busy && !byte_vld))
                ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("frame_done", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_obs(input string nm, input byte_q_t lit);
        check({nm, "_len"}, obs_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < obs_q.size(); i++) check(nm, 32'(obs_q[i]), 32'(lit[i]));
    endtask

    // Compare process: every transfer against the model, hold-stable under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_m = 1'b0;
                end_pend = 1'b0;
            end else begin
                if (end_pend) begin
                    check("rdy_after_frame", 32'(pkt_rdy), 32'(end_cts));
                    check("busy_after_frame", 32'(busy), 32'd0);
                    end_pend = 1'b0;
                end
                if (stall_m) begin
                    check("hold_vld", 32'(byte_vld), 32'd1);
                    check("hold_data", 32'(byte_data), 32'(held_m));
                end
                if (byte_vld && byte_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected no byte", byte_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("byte", 32'(byte_data), 32'(exp_b));
                        obs_q.push_back(byte_data);
                        obs_cyc_q.push_back(cyc + 1);
                        xfer_cnt++;
                        if (exp_q.size() == 0) begin
                            end_pend = 1'b1;
                            end_cts = cts;
                        end
                    end
                end
                stall_m = byte_vld && !byte_rdy;
                held_m = byte_data;
                if (g_byte_vld && byte_rdy) begin
                    if (exp_g_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_gap_byte: got %02h expected no byte", g_byte_data);
                    end else begin
                        exp_b = exp_g_q.pop_front();
                        check("gap_byte", 32'(g_byte_data), 32'(exp_b));
                        g_last_cyc = cyc + 1;
                    end
                end
                if (g_busy && !g_byte_vld) g_gap_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, base;
        lit1 = '{8'h7E, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        lit2 = '{8'h7E, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef SPIO_UART_PKT_SER_CHECKSUM_EN
        lit1.push_back(8'h08);
        lit2.push_back(8'h21);
`endif
        rst_n = 1'b0; cts = 1'b0; pkt_vld = 1'b0; pkt_vld_g = 1'b0; byte_rdy = 1'b1; pkt_data = 72'h0;
        #12;
        check("rst_rdy", 32'(pkt_rdy), 32'd0);
        check("rst_vld", 32'(byte_vld), 32'd0);
        check("rst_data", 32'(byte_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_g_vld", 32'(g_byte_vld), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; cts = 1'b1;
        @(posedge clk); #1;
        check("idle_rdy", 32'(pkt_rdy), 32'd1);

        // Case 1: header only, continuously ready sink.
        obs_q.delete(); obs_cyc_q.delete();
        send(1'b0, 8'h00, 32'h12345678, 32'h0);
        wait_done(1'b0);
        check_obs("case1", lit1);
        check("case1_first_latency", obs_cyc_q[0], acc_cyc + 1);
        check("case1_consecutive", obs_cyc_q[obs_cyc_q.size()-1] - obs_cyc_q[0], obs_cyc_q.size() - 1);

        // Case 2: payload present.
        obs_q.delete(); obs_cyc_q.delete();
        send(1'b0, 8'h02, 32'h00000001, 32'hDEADBEEF);
        wait_done(1'b0);
        check_obs("case2", lit2);

        // Case 3: five-cycle stall on the third byte.
        obs_q.delete(); obs_cyc_q.delete();
        send(1'b0, 8'h00, 32'h12345678, 32'h0);
        for (int i = 0; i < 20 && !(byte_vld && byte_data == 8'h78); i++) begin
            @(posedge clk); #1;
        end
        byte_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data", 32'(byte_data), 32'h78);
            check("stall_vld", 32'(byte_vld), 32'd1);
            @(posedge clk); #1;
        end
        byte_rdy = 1'b1;
        wait_done(1'b0);
        check_obs("case3", lit1);

        // Case 4: CTS gating of packet start, CTS drop mid-frame.
        cts = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pkt_data = {32'h0, 32'h12345678, 8'h00};
        pkt_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("cts_block_rdy", 32'(pkt_rdy), 32'd0);
            check("cts_block_vld", 32'(byte_vld), 32'd0);
        end
        @(posedge clk); #1;
        cts = 1'b1;
        c = cyc;
        obs_q.delete(); obs_cyc_q.delete();
        send(1'b0, 8'h00, 32'h12345678, 32'h0);
        check("cts_accept_edge", acc_cyc, c + 2);
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        cts = 1'b0;
        wait_done(1'b0);
        check_obs("case4", lit1);
        check("case4_first_latency", obs_cyc_q[0], acc_cyc + 1);
        cts = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Case 5: three idle gap cycles between back-to-back frames.
        g_gap_cnt = 0;
        send(1'b1, 8'h00, 32'h12345678, 32'h0);
        send(1'b1, 8'h02, 32'h00000001, 32'hDEADBEEF);
        check("gap_cycles", g_gap_at_acc, 3);
        check("gap_accept_dist", acc_cyc - g_last_cyc, 4);
        wait_done(1'b1);

        // Case 6: reset during the key bytes, then a clean frame.
        base = xfer_cnt;
        send(1'b0, 8'h02, 32'h00000001, 32'hDEADBEEF);
        for (int i = 0; i < 20 && xfer_cnt < base + 3; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_vld", 32'(byte_vld), 32'd0);
        check("midrst_rdy", 32'(pkt_rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs_q.delete(); obs_cyc_q.delete();
        send(1'b0, 8'h00, 32'h12345678, 32'h0);
        wait_done(1'b0);
        check_obs("case6", lit1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spio_uart_pkt_ser.md
Name: spio_uart_pkt_ser

Overview:
Packet-to-byte serialiser that sits directly upstream of spio_uart_tx.
- Accepts one 72-bit SpiNNaker packet at a time and emits a framed byte stream on a valid/ready interface: sync byte, header, key, optional payload, optional checksum.
- The byte stream drives spio_uart_tx DATA_IN/VLD_IN/RDY_OUT.
- Packet starts are gated by the synchronised CTS from the far-end receiver.

Parameters:
SYNC_BYTE, 8'h7E, first byte of every frame.
GAP_CYCLES, 0, idle clock cycles inserted after each frame before the next packet is accepted (0 = none).

Ports:
tx_clk_i  input  1  clock; all logic rising-edge.
rx_reset_i  input  1  reset, asynchronous, active-low.
PKT_DATA_IN  input  72  [7:0] header, [39:8] key, [71:40] payload; header bit 1 = payload present.
PKT_VLD_IN  input  1  packet valid.
PKT_RDY_OUT  output  1  packet ready.
CTS_IN  input  1  clear-to-send, already synchronised to tx_clk_i.
BYTE_DATA_OUT  output  8  byte to UART TX.
BYTE_VLD_OUT  output  1  byte valid.
BYTE_RDY_IN  input  1  UART TX ready.
BUSY_OUT  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: clock tx_clk_i; reset rx_reset_i, asynchronous, active-low.
- Reset values (asynchronous): state IDLE; PKT_RDY_OUT 0; BYTE_VLD_OUT 0; BYTE_DATA_OUT 8'h00; BUSY_OUT 0; byte counter 0; checksum 0; gap counter 0.
- All outputs are registered.
- States: IDLE, SYNC, HDR, KEY, PLD, CHK, GAP.
- PKT_RDY_OUT is 1 only in IDLE with CTS_IN=1, computed from the next-state value so that it is registered.
- Packet acceptance: PKT_VLD_IN && PKT_RDY_OUT. On acceptance:
  - latch the packet into a 72-bit holding register;
  - clear the checksum;
  - go to SYNC with BYTE_DATA_OUT=SYNC_BYTE and BYTE_VLD_OUT=1 on the next edge.
  - Latency from accept edge to first byte valid: 1 cycle.
- Byte transfer: BYTE_VLD_OUT && BYTE_RDY_IN at a rising edge.
  - While BYTE_VLD_OUT=1 and BYTE_RDY_IN=0, BYTE_DATA_OUT and BYTE_VLD_OUT hold stable.
  - BYTE_VLD_OUT never drops without a transfer, except on reset.
- Transitions (each taken on a byte transfer):
  - SYNC -> HDR: emit header.
  - HDR -> KEY: emit key bits [7:0] (key sent LSB byte first).
  - KEY steps the counter 0..3. After the 4th key byte: go to PLD if header bit 1=1, else go to CHK.
  - PLD: 4 payload bytes, LSB first, then CHK.
  - CHK: emit checksum. After its transfer, go to GAP if GAP_CYCLES>0, else IDLE.
- Back-to-back bytes: the next byte is presented in the cycle immediately after a transfer, so a continuously ready sink sees one byte per cycle.
- Checksum: running 8-bit XOR of header, key and payload bytes only (SYNC excluded). Updated on each of those transfers.
- GAP: counter loads GAP_CYCLES-1 on entry, decrements each cycle, exits to IDLE at 0. Counter width max(1,$clog2(GAP_CYCLES+1)).
- CTS:
  - Only gates packet start.
  - CTS_IN falling mid-frame does not stall or alter the frame; flow control within a frame is via BYTE_RDY_IN only.
  - CTS_IN low in IDLE holds PKT_RDY_OUT=0 indefinitely.
- Simultaneous events: a transfer of the final byte and PKT_VLD_IN=1 in the same cycle does not accept the packet (PKT_RDY_OUT was 0). Acceptance is earliest the cycle after returning to IDLE.
- Reset mid-frame: the partial frame is abandoned. BYTE_VLD_OUT drops immediately (asynchronous). After release, the block resumes in IDLE; the held packet is lost.
- No packet buffering beyond the single holding register.

Optional Feature:
SPIO_UART_PKT_SER_CHECKSUM_EN
- Defined: CHK state present; checksum byte appended as above.
- Undefined: CHK state and checksum logic omitted. After the last key byte (no payload) or last payload byte, go directly to GAP/IDLE. Frames are 1 byte shorter.

Test Plan:
1. Header 8'h00, key 32'h12345678, sink always ready, checksum enabled -> bytes 7E 00 78 56 34 12 08 on consecutive cycles. PKT_RDY_OUT high again 1 cycle after the last transfer.
2. Header 8'h02, key 32'h00000001, payload 32'hDEADBEEF -> bytes 7E 02 01 00 00 00 EF BE AD DE 21. Without SPIO_UART_PKT_SER_CHECKSUM_EN -> same sequence without the final 21.
3. Backpressure: hold BYTE_RDY_IN=0 for 5 cycles on the 3rd byte of case 1 -> BYTE_DATA_OUT stays 78 and BYTE_VLD_OUT stays 1 for all 5 cycles; sequence otherwise unchanged.
4. CTS_IN=0 with PKT_VLD_IN=1 for 20 cycles -> PKT_RDY_OUT=0, no bytes emitted. CTS_IN->1 -> packet accepted next edge, 7E emitted 1 cycle later. CTS_IN dropped after byte 2 -> frame completes unchanged.
5. GAP_CYCLES=3, two packets presented back to back -> exactly 3 cycles with BUSY_OUT=1 and BYTE_VLD_OUT=0 between the last byte of frame 1 and the accept of frame 2.
6. Assert rx_reset_i=0 during the KEY state of case 2 -> BYTE_VLD_OUT=0 and PKT_RDY_OUT=0 immediately. After release with CTS_IN=1, a new packet 00/12345678 yields exactly the case 1 sequence.
